// File: rtl/fpu_share_sched_pkg.sv
// Shared types and helpers for the FPU sharing scheduler.
package FPU_sched_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_MUL = 1'b1
   } fpu_op_e;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      IDLE
   } sched_state_e;

   localparam int unsigned MAX_REQ = 8;

   // Callers truncate the result to their own requester count.
   function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
      logic [MAX_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fpu_share_sched_arb.sv
// Round-robin arbiter: combinational grant from a registered priority pointer.
module rr_arbiter
   import FPU_sched_pkg::*;
#(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    gnt_id,
   output logic             gnt_valid
);

   logic [IW-1:0] ptr;

   always_comb begin
      int unsigned idx;
      gnt_valid = 1'b0;
      gnt_id    = '0;
      idx       = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (en && !gnt_valid && req[IW'(idx)]) begin
            gnt_valid = 1'b1;
            gnt_id    = IW'(idx);
         end
      end
   end

   assign grant = gnt_valid ? N_REQ'(onehot(3'(gnt_id))) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (gnt_valid) begin
         ptr <= (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + IW'(1);
      end
   end

endmodule

// File: rtl/fpu_share_sched.sv
// Time-multiplexes one pipelined FPU among N_REQ requesters; results are
// routed back to the issuing requester via a tag pipe matched to FPU latency.
module fpu_share_sched
   import FPU_sched_pkg::*;
#(
   parameter  int unsigned N_REQ   = 4,
   parameter  int unsigned n_exp   = 8,
   parameter  int unsigned n_mant  = 23,
   parameter  int unsigned FPU_LAT = 3,
   localparam int unsigned W       = 1 + n_exp + n_mant
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ-1:0]         req_op,
   input  logic [N_REQ-1:0][W-1:0]  req_a,
   input  logic [N_REQ-1:0][W-1:0]  req_b,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     fpu_valid,
   output logic                     fpu_op,
   output logic [W-1:0]             fpu_a,
   output logic [W-1:0]             fpu_b,
   input  logic [W-1:0]             fpu_result,
   output logic [N_REQ-1:0]         res_valid,
   output logic [W-1:0]             res_data,
   input  logic                     flush,
   output logic                     idle
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CW = $clog2(FPU_LAT + 2);

   sched_state_e               state, state_nx;
   logic                       gnt_valid;
   logic [IW-1:0]              gnt_id;
   fpu_op_e                    op_q;
   logic [FPU_LAT:0]           tag_v;
   logic [FPU_LAT:0][IW-1:0]   tag_id;
   logic [CW-1:0]              cnt;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .en        (state == RUN),
      .req       (req_valid),
      .grant     (req_ready),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Dropping flush mid-drain still finishes the drain and visits IDLE once.
   always_comb begin
      state_nx = state;
      case (state)
         RUN:     if (flush)       state_nx = DRAIN;
         DRAIN:   if (cnt == '0)   state_nx = IDLE;
         IDLE:    if (!flush)      state_nx = RUN;
         default:                  state_nx = IDLE;
      endcase
   end

   assign idle   = (state == IDLE);
   assign fpu_op = op_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpu_valid <= 1'b0;
         fpu_a     <= '0;
         fpu_b     <= '0;
         op_q      <= OP_ADD;
         tag_v     <= '0;
         tag_id    <= '0;
         cnt       <= '0;
         res_valid <= '0;
         res_data  <= '0;
      end else begin
         fpu_valid <= gnt_valid;
         if (gnt_valid) begin
            fpu_a <= req_a[gnt_id];
            fpu_b <= req_b[gnt_id];
            op_q  <= fpu_op_e'(req_op[gnt_id]);
         end
         tag_v  <= {tag_v[FPU_LAT-1:0], gnt_valid};
         tag_id <= {tag_id[FPU_LAT-1:0], gnt_id};
         res_valid <= tag_v[FPU_LAT] ? N_REQ'(onehot(3'(tag_id[FPU_LAT]))) : '0;
         if (tag_v[FPU_LAT]) res_data <= fpu_result;
         case ({gnt_valid, tag_v[FPU_LAT]})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_share_sched.sv
// Directed and scoreboarded checks for fpu_share_sched with a stand-in FPU.
module tb_fpu_share_sched;

   localparam int unsigned N   = 4;
   localparam int unsigned LAT = 3;
   localparam int unsigned W   = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 flush;
   logic [N-1:0]         req_valid, req_op, req_ready, res_valid;
   logic [N-1:0][W-1:0]  req_a, req_b;
   logic                 fpu_valid, fpu_op, idle;
   logic [W-1:0]         fpu_a, fpu_b, fpu_result, res_data;
   logic [W-1:0]         pipe [LAT];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] d;
   } exp_t;
   exp_t q[$];
   exp_t e;

   fpu_share_sched #(.N_REQ(N), .n_exp(8), .n_mant(23), .FPU_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .fpu_valid(fpu_valid), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_result(fpu_result), .res_valid(res_valid), .res_data(res_data),
      .flush(flush), .idle(idle)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] sp2dp(input logic [31:0] x);
      if (x[30:23] == 8'd0) return {x[31], 63'd0};
      return {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
   endfunction

   function automatic logic [31:0] dp2sp(input logic [63:0] d);
      logic [10:0] ex;
      if (d[62:52] == 11'd0) return {d[63], 31'd0};
      ex = d[62:52] - 11'd896;
      return {d[63], ex[7:0], d[51:29]};
   endfunction

   // Operands stay in a narrow exponent range, so double arithmetic is exact.
   function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b, input logic op);
      real ra, rb, rr;
      ra = $bitstoreal(sp2dp(a));
      rb = $bitstoreal(sp2dp(b));
      rr = op ? ra * rb : ra + rb;
      return dp2sp($realtobits(rr));
   endfunction

   function automatic logic [31:0] rnd_f();
      return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
   endfunction

   always @(posedge clk) begin
      pipe[0] <= fpu_valid ? fmodel(fpu_a, fpu_b, fpu_op) : 32'hDEADBEEF;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign fpu_result = pipe[LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [31:0] exp_r [4] = '{32'h40400000, 32'h40C00000, 32'h40E00000, 32'h40000000};
   logic [3:0]  rdy_e [11] = '{4'b1000, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                               4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
   logic [3:0]  res_e [11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000,
                               4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};

   initial begin
      rst = 1'b1; flush = 1'b0; req_valid = '0;
      req_a[0] = 32'h3F800000; req_b[0] = 32'h40000000; req_op[0] = 1'b0;
      req_a[1] = 32'h40000000; req_b[1] = 32'h40400000; req_op[1] = 1'b1;
      req_a[2] = 32'h40400000; req_b[2] = 32'h40800000; req_op[2] = 1'b0;
      req_a[3] = 32'h40800000; req_b[3] = 32'h3F000000; req_op[3] = 1'b1;
      tick(); tick();

      // Reset state
      req_valid = 4'hF; #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_fpu_valid", fpu_valid, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_fpu_a", fpu_a, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_idle", idle, 1);
      req_valid = '0; rst = 1'b0; #1;
      chk("rel_idle", idle, 1);
      tick();
      chk("run_idle", idle, 0);

      // All requesters valid: round-robin from ptr=0
      for (int k = 0; k < 13; k++) begin
         req_valid = (k < 8) ? 4'hF : 4'h0; #1;
         if (k < 8) chk("rr_order", req_ready, 4'b0001 << (k % 4));
         if (k >= 1 && k < 5) chk("rr_no_res", res_valid, 0);
         if (k >= 5) begin
            chk("rr_res_id", res_valid, 4'b0001 << ((k - 5) % 4));
            chk("rr_res_data", res_data, exp_r[(k - 5) % 4]);
         end
         tick();
      end

      // Single add on requester 0, latency FPU_LAT+2
      req_valid = 4'b0001; #1;
      chk("single_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0; #1;
      chk("single_fpu_valid", fpu_valid, 1);
      chk("single_fpu_a", fpu_a, 32'h3F800000);
      chk("single_fpu_b", fpu_b, 32'h40000000);
      chk("single_fpu_op", fpu_op, 0);
      tick(); tick(); tick();
      chk("single_early", res_valid, 0);
      tick();
      chk("single_res_valid", res_valid, 4'b0001);
      chk("single_res_data", res_data, 32'h40400000);
      tick();
      chk("single_res_pulse", res_valid, 0);

      // Requesters 1 and 3 with ptr=2
      req_valid = 4'b0010; #1;
      chk("p2_setup", req_ready, 4'b0010);
      tick();
      req_valid = 4'b1010; #1;
      chk("p2_first", req_ready, 4'b1000);
      tick();
      chk("p2_second", req_ready, 4'b0010);
      tick();
      req_valid = 4'hF; #1;
      chk("p2_ptr", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      for (int k = 0; k < 6; k++) tick();

      // Flush with 3 operations in flight, then resume
      for (int k = 0; k < 11; k++) begin
         req_valid = 4'hF;
         flush = (k >= 2 && k < 9); #1;
         chk("fl_ready", req_ready, rdy_e[k]);
         chk("fl_res_valid", res_valid, res_e[k]);
         if (k == 5) chk("fl_res_data", res_data, exp_r[3]);
         if (k == 6) chk("fl_res_data", res_data, exp_r[0]);
         if (k == 7) chk("fl_res_data", res_data, exp_r[1]);
         chk("fl_idle", idle, (k == 8 || k == 9));
         tick();
      end

      // Reset with 2 operations in flight
      req_valid = 4'b0001; #1;
      chk("pre_rst_ready", req_ready, 4'b0001);
      tick();
      req_valid = 4'b1001; rst = 1'b1; #1;
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_fpu_valid", fpu_valid, 0);
      chk("mid_rst_fpu_a", fpu_a, 0);
      chk("mid_rst_fpu_b", fpu_b, 0);
      chk("mid_rst_fpu_op", fpu_op, 0);
      chk("mid_rst_res_valid", res_valid, 0);
      chk("mid_rst_res_data", res_data, 0);
      chk("mid_rst_idle", idle, 1);
      tick(); tick();
      rst = 1'b0; #1;
      chk("post_rst_ready", req_ready, 0);
      tick();
      chk("post_rst_grant", req_ready, 4'b0001);
      chk("post_rst_no_res", res_valid, 0);
      tick();
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("post_rst_no_res", res_valid, 0);
         tick();
      end
      chk("post_rst_res_valid", res_valid, 4'b0001);
      chk("post_rst_res_data", res_data, exp_r[0]);
      tick();

      // Random traffic against a scoreboard
      for (int i = 0; i < 24012; i++) begin
         if (i < 24000) begin
            if ($urandom_range(0, 299) == 0) flush = ~flush;
            req_valid = 4'($urandom);
            for (int r = 0; r < 4; r++) begin
               req_op[r] = 1'($urandom);
               req_a[r]  = rnd_f();
               req_b[r]  = rnd_f();
            end
         end else begin
            flush = 1'b0;
            req_valid = '0;
         end
         #1;
         chk("rnd_ready_legal", {63'd0, $onehot0(req_ready) && ((req_ready & ~req_valid) == 0)}, 1);
         if (res_valid != 0) begin
            if (q.size() == 0) begin
               chk("rnd_spurious_res", res_valid, 0);
            end else begin
               e = q.pop_front();
               chk("rnd_res_id", res_valid, 4'b0001 << e.id);
               chk("rnd_res_data", res_data, e.d);
            end
         end
         chk("rnd_inflight", {63'd0, q.size() <= LAT + 1}, 1);
         for (int r = 0; r < 4; r++) begin
            if (req_ready[r] && req_valid[r]) begin
               e.id = 2'(r);
               e.d  = fmodel(req_a[r], req_b[r], req_op[r]);
               q.push_back(e);
            end
         end
         tick();
      end
      chk("rnd_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
